// File: rtl/dot_pkg.sv
// dot_pkg: FSM state type, width helpers and default parameters for dot_product_engine
package dot_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam int DEF_LANES = 4;
  localparam int DEF_ELEM_W = 8;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_MAX_BEATS = 256;
  function automatic int prod_w(input int ew);
    return 2 * ew;
  endfunction
  function automatic int sum_w(input int ew, input int lanes);
    return 2 * ew + $clog2(lanes);
  endfunction
endpackage

// File: rtl/dot_product_engine_lane_array.sv
// dot_lane_array: per-lane multipliers with stage-1 product register and adder tree widened to ACC_W
module dot_lane_array
  import dot_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    sgn,
  input  logic [LANES*ELEM_W-1:0] in_a,
  input  logic [LANES*ELEM_W-1:0] in_b,
  output logic                    valid,
  output logic [ACC_W-1:0]        sum
);
  localparam int PW = prod_w(ELEM_W);
  logic [PW-1:0] prod_d [LANES];
  logic [PW-1:0] prod_q [LANES];
  logic          vld_d, vld_q;
  function automatic logic [PW-1:0] ext(input logic [ELEM_W-1:0] x, input logic s);
    return s ? PW'($signed(x)) : PW'(x);
  endfunction
  always_comb begin
    vld_d = in_valid;
    for (int k = 0; k < LANES; k++)
      prod_d[k] = ext(in_a[k*ELEM_W +: ELEM_W], sgn) * ext(in_b[k*ELEM_W +: ELEM_W], sgn);
  end
  always_ff @(posedge clk) begin
    vld_q  <= rst_n ? vld_d : 1'b0;
    prod_q <= prod_d;
  end
  always_comb begin
    sum = '0;
    for (int k = 0; k < LANES; k++)
      sum = sum + (sgn ? ACC_W'($signed(prod_q[k])) : ACC_W'(prod_q[k]));
  end
  assign valid = vld_q;
endmodule

// File: rtl/dot_product_engine.sv
// dot_product_engine: multi-beat dot-product MAC with sticky overflow; DOT_SATURATE_EN clamps instead of wrapping
module dot_product_engine
  import dot_pkg::*;
#(
  parameter int LANES     = DEF_LANES,
  parameter int ELEM_W    = DEF_ELEM_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [$clog2(MAX_BEATS+1)-1:0]   cmd_len,
  input  logic                             cmd_signed,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*ELEM_W-1:0]          in_a,
  input  logic [LANES*ELEM_W-1:0]          in_b,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_W-1:0]                 out_result,
  output logic                             out_overflow
);
  localparam int CW = $clog2(MAX_BEATS + 1);
  if (ACC_W < sum_w(ELEM_W, LANES)) begin : g_acc_w_check
    $error("dot_product_engine: ACC_W too narrow for LANES and ELEM_W");
  end
  state_e           state_d, state_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic             sgn_d, sgn_q;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic             ovf_d, ovf_q;
  logic             lane_vld, add_ovf;
  logic [ACC_W-1:0] lane_sum, add_res;
  logic [ACC_W:0]   add;
  dot_lane_array #(.LANES(LANES), .ELEM_W(ELEM_W), .ACC_W(ACC_W)) u_lanes (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid && in_ready),
    .sgn      (sgn_q),
    .in_a     (in_a),
    .in_b     (in_b),
    .valid    (lane_vld),
    .sum      (lane_sum)
  );
  assign cmd_ready    = rst_n && state_q == IDLE;
  assign in_ready     = state_q == RUN;
  assign out_valid    = state_q == DONE;
  assign out_result   = acc_q;
  assign out_overflow = ovf_q;
  always_comb begin
    add     = {1'b0, acc_q} + {1'b0, lane_sum};
    add_ovf = sgn_q ? (acc_q[ACC_W-1] == lane_sum[ACC_W-1] && add[ACC_W-1] != acc_q[ACC_W-1])
                    : add[ACC_W];
`ifdef DOT_SATURATE_EN
    add_res = !add_ovf ? add[ACC_W-1:0] :
              !sgn_q ? {ACC_W{1'b1}} :
              lane_sum[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
    add_res = add[ACC_W-1:0];
`endif
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    acc_d   = lane_vld ? add_res : acc_q;
    ovf_d   = ovf_q | (lane_vld & add_ovf);
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        cnt_d   = cmd_len;
        sgn_d   = cmd_signed;
        acc_d   = '0;
        ovf_d   = 1'b0;
        state_d = cmd_len == '0 ? DONE : RUN;
      end
      RUN: if (in_valid) begin
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? DRAIN : RUN;
      end
      DRAIN: state_d = lane_vld ? DRAIN : DONE;
      DONE:  state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_dot_product_engine.sv
// tb_dot_product_engine: table, hand-written and randomized checks against an integer reference model
module tb_dot_product_engine;
  localparam int CLW = 9;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic             cmd_valid = 0, cmd_ready, cmd_signed = 0, in_valid = 0, in_ready;
  logic             out_valid, out_ready = 0, out_overflow;
  logic [CLW-1:0]   cmd_len = '0;
  logic [31:0]      in_a = '0, in_b = '0, out_result;
  logic             s_cmd_valid = 0, s_cmd_ready, s_cmd_signed = 0, s_in_valid = 0, s_in_ready;
  logic             s_out_valid, s_out_ready = 0, s_out_overflow;
  logic [CLW-1:0]   s_cmd_len = '0;
  logic [31:0]      s_in_a = '0, s_in_b = '0;
  logic [17:0]      s_out_result;
  int n_chk = 0, n_fail = 0;
  logic [31:0] qa[$], qb[$];
  typedef struct { logic [31:0] a, b; bit sg; logic [31:0] res; } vec_t;
  vec_t tbl[7];

  dot_product_engine u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_signed(cmd_signed), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_overflow(out_overflow)
  );
  dot_product_engine #(.ACC_W(18)) u_dut18 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_len(s_cmd_len),
    .cmd_signed(s_cmd_signed), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a),
    .in_b(s_in_b), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_result(s_out_result),
    .out_overflow(s_out_overflow)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint ev(input logic [7:0] x, input bit sg);
    return sg ? longint'($signed(x)) : longint'(x);
  endfunction

  function automatic void model(input int len, input bit sg, input int accw,
                                output longint r, output bit o);
    longint acc, lo, hi, m;
    m  = longint'(1) <<< accw;
    lo = sg ? -(m / 2) : 0;
    hi = sg ? m / 2 - 1 : m - 1;
    acc = 0;
    o = 0;
    for (int i = 0; i < len; i++) begin
      for (int k = 0; k < 4; k++) acc += ev(qa[i][8*k +: 8], sg) * ev(qb[i][8*k +: 8], sg);
      if (acc < lo || acc > hi) begin
        o = 1;
`ifdef DOT_SATURATE_EN
        acc = acc < lo ? lo : hi;
`else
        acc = ((acc - lo) % m + m) % m + lo;
`endif
      end
    end
    r = acc;
  endfunction

  task automatic run_cmd(input int len, input bit sg, input int gap, input int hold,
                         input logic [31:0] er, input bit eo, input string nm);
    logic [31:0] r0;
    bit bad;
    chk({nm, " cmd_ready idle"}, cmd_ready, 1);
    cmd_valid = 1; cmd_len = CLW'(len); cmd_signed = sg;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_signed = !sg;
    for (int i = 0; i < len; i++) begin
      in_valid = 0;
      if (i > 0) repeat (gap) begin @(posedge clk); #1; end
      chk({nm, " in_ready before beat"}, in_ready, 1);
      in_valid = 1; in_a = qa[i]; in_b = qb[i];
      @(posedge clk); #1;
    end
    in_valid = 0;
    if (len > 0) begin
      chk({nm, " in_ready after last"}, in_ready, 0);
      chk({nm, " out_valid edge0"}, out_valid, 0);
      @(posedge clk); #1;
      chk({nm, " out_valid edge1"}, out_valid, 0);
      @(posedge clk); #1;
    end
    chk({nm, " out_valid latency"}, out_valid, 1);
    r0 = out_result; bad = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      bad |= (out_result !== r0) || (cmd_ready !== 0) || (out_valid !== 1) || (in_ready !== 0);
    end
    if (hold > 0) chk({nm, " hold stable"}, bad, 0);
    chk({nm, " result"}, out_result, er);
    chk({nm, " overflow"}, out_overflow, eo);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({nm, " out_valid after hs"}, out_valid, 0);
    chk({nm, " cmd_ready after hs"}, cmd_ready, 1);
  endtask

  task automatic run18(input int len, input bit sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [17:0] er, input string nm);
    s_cmd_valid = 1; s_cmd_len = CLW'(len); s_cmd_signed = sg;
    @(posedge clk); #1;
    s_cmd_valid = 0;
    s_in_valid = 1; s_in_a = a; s_in_b = b;
    repeat (len) @(posedge clk);
    #1 s_in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk({nm, " out_valid"}, s_out_valid, 1);
    chk({nm, " result"}, s_out_result, er);
    chk({nm, " overflow"}, s_out_overflow, 1);
    s_out_ready = 1;
    @(posedge clk); #1;
    s_out_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, gap, hold;
    bit sg, bad;
    longint mr;
    bit mo;
    tbl[0] = '{32'h01020304, 32'h05060708, 1'b0, 32'd70};
    tbl[1] = '{32'hFFFFFFFF, 32'h01010101, 1'b1, 32'hFFFFFFFC};
    tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd260100};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd4};
    tbl[4] = '{32'h80808080, 32'h80808080, 1'b1, 32'd65536};
    tbl[5] = '{32'h80808080, 32'h7F7F7F7F, 1'b1, 32'hFFFF0200};
    tbl[6] = '{32'h80808080, 32'h80808080, 1'b0, 32'd65536};
    repeat (2) @(posedge clk);
    #1;
    chk("reset cmd_ready", cmd_ready, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_result", out_result, 0);
    chk("reset out_overflow", out_overflow, 0);
    rst_n = 1;
    #1;
    for (int i = 0; i < 7; i++) begin
      qa = {tbl[i].a}; qb = {tbl[i].b};
      run_cmd(1, tbl[i].sg, 0, 1, tbl[i].res, 0, $sformatf("tbl%0d", i));
    end
    qa = {32'h01020304, 32'h01020304, 32'h01020304};
    qb = {32'h05060708, 32'h05060708, 32'h05060708};
    run_cmd(3, 0, 2, 5, 32'd210, 0, "gaps_backpressure");
    run_cmd(0, 0, 0, 0, 32'd0, 0, "zero_len");
    cmd_valid = 1; cmd_len = 3; cmd_signed = 0;
    @(posedge clk); #1;
    cmd_valid = 0;
    in_valid = 1; in_a = 32'h01020304; in_b = 32'h05060708;
    @(posedge clk); #1;
    in_valid = 0; rst_n = 0;
    @(posedge clk); #1;
    chk("midrst cmd_ready", cmd_ready, 0);
    chk("midrst in_ready", in_ready, 0);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_result", out_result, 0);
    chk("midrst out_overflow", out_overflow, 0);
    rst_n = 1; bad = 0;
    repeat (4) begin @(posedge clk); #1; bad |= (out_valid !== 0); end
    chk("midrst no result", bad, 0);
    qa = {32'h01020304}; qb = {32'h05060708};
    run_cmd(1, 0, 0, 0, 32'd70, 0, "after_midrst");
`ifdef DOT_SATURATE_EN
    run18(2, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 18'd262143, "ovf18_unsigned");
    run18(3, 1, 32'h80808080, 32'h80808080, 18'h1FFFF, "ovf18_signed");
`else
    run18(2, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 18'd258056, "ovf18_unsigned");
    run18(3, 1, 32'h80808080, 32'h80808080, 18'h30000, "ovf18_signed");
`endif
    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(0, 6); sg = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2); hold = $urandom_range(0, 2);
      qa.delete(); qb.delete();
      for (int i = 0; i < len; i++) begin
        qa.push_back($urandom); qb.push_back($urandom);
      end
      model(len, sg, 32, mr, mo);
      run_cmd(len, sg, gap, hold, mr[31:0], mo, $sformatf("rand%0d", r));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dot_product_engine.md
Name: dot_product_engine

Overview:
Parametrised multi-beat dot-product / MAC engine. It is the next generation of the packed-integer multiply unit in the TPU datapath.
- Accepts a command giving beat count and signedness, then LANES-wide operand beats over a valid/ready stream.
- Accumulates the per-beat lane sums across the burst.
- Returns one ACC_W result, with an overflow flag, over a valid/ready output.
- Sits between the operand fetch stream and the result writeback.

Parameters:
LANES, 4, number of element lanes per beat (power of two, >=1)
ELEM_W, 8, element width in bits
ACC_W, 32, accumulator/result width; must be >= 2*ELEM_W+$clog2(LANES) (elaboration assertion)
MAX_BEATS, 256, maximum beats per command

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both high
cmd_len  in  $clog2(MAX_BEATS+1)  beats in burst, 0..MAX_BEATS
cmd_signed  in  1  1 = two's-complement elements, 0 = unsigned
in_valid  in  1  operand beat offered
in_ready  out  1  beat accepted when both high
in_a  in  LANES*ELEM_W  lane k = bits [k*ELEM_W +: ELEM_W]
in_b  in  LANES*ELEM_W  same packing as in_a
out_valid  out  1  result available
out_ready  in  1  result consumed when both high
out_result  out  ACC_W  accumulated dot product
out_overflow  out  1  sticky overflow for this command

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE; beat counter, accumulator, pipeline valids and overflow cleared. Outputs: cmd_ready=0 during reset, then 1 in IDLE. in_ready=0, out_valid=0, out_result=0, out_overflow=0.
- Reset mid-burst aborts the burst. Pending pipeline data is discarded and no result is produced.
- FSM, IDLE:
  - cmd_ready=1.
  - On a cmd handshake, latch cmd_len and cmd_signed, then clear accumulator and overflow.
  - cmd_len>0 goes to RUN; cmd_len==0 goes to DONE on the next edge with result 0.
- FSM, RUN:
  - in_ready=1; each beat handshake decrements the remaining count.
  - The handshake on the last beat goes to DRAIN.
  - in_valid low stalls with no side effects.
- FSM, DRAIN: wait until the pipeline is empty, then go to DONE.
- FSM, DONE:
  - out_valid=1; out_result and out_overflow are held stable until out_ready.
  - On the handshake, go to IDLE. cmd_ready returns the following cycle; there is no same-cycle cmd/out overlap.
- Pipeline stage 1 (registered):
  - Per-lane product, 2*ELEM_W bits.
  - Operands are sign-extended if the latched signed flag is set, zero-extended otherwise.
- Pipeline stage 2 (registered):
  - Adder tree sums the lane products, widened to ACC_W by the same extension rule.
  - The sum is added to the accumulator.
- Latency: out_valid rises on the 2nd rising edge after the edge accepting the last beat.
- Throughput: one beat per cycle; there is no bubble between beats.
- Wrap-around:
  - The accumulator wraps modulo 2^ACC_W.
  - Overflow is detected per add: unsigned carry-out, or signed overflow (operand signs equal and result sign different).
  - out_overflow is sticky until the next command.
- Signedness is fixed for a whole command; changes on cmd_signed mid-burst are ignored.

Optional Feature:
Macro DOT_SATURATE_EN.
- Defined: on overflow the accumulator clamps and stays clamped while further adds push it the same way. Clamp values:
  - unsigned: 2^ACC_W-1
  - signed: +(2^(ACC_W-1)-1) or -2^(ACC_W-1)
  - out_overflow is still set.
- Undefined: modulo wrap as above. No saturation logic is synthesised.

Decomposition:
- Package dot_pkg:
  - FSM state enum (IDLE, RUN, DRAIN, DONE)
  - width helper functions (product width, sum width)
  - default parameter constants
- Sub-module dot_lane_array: LANES multipliers plus adder tree plus stage-1 register, with a signed select input. The top holds the FSM, counter, accumulator and handshakes.

Test Plan:
- Unsigned single beat: LANES=4, ELEM_W=8, cmd_len=1, cmd_signed=0, in_a=32'h01020304, in_b=32'h05060708 -> out_result=32'd70, out_overflow=0, out_valid 2 edges after the beat.
- Signed single beat: in_a=32'hFFFFFFFF, in_b=32'h01010101, cmd_signed=1 -> out_result=32'hFFFFFFFC, out_overflow=0.
- Multi-beat with gaps: cmd_len=3, same unsigned operands as the first scenario, in_valid deasserted 2 cycles between beats -> out_result=210; in_ready drops only after the 3rd beat.
- Overflow: ACC_W=18, unsigned, cmd_len=2, in_a=in_b=32'hFFFFFFFF -> without DOT_SATURATE_EN result=258056 and out_overflow=1; with it, result=262143 and out_overflow=1.
- Backpressure and zero length:
  - out_ready held low 5 cycles: out_result is stable and cmd_ready=0.
  - After the handshake, cmd_len=0: out_valid=1 next cycle with out_result=0, and no beats are consumed.
- Reset mid-burst: rst_n=0 after 1 of 3 beats -> all outputs at reset values, no out_valid. A following cmd_len=1 (first-scenario operands) gives a clean result of 70.
